// File: rtl/led_arb_pkg.sv
// Shared definitions for the LED write arbiter: FSM encodings, hold counter
// width and master index constants.
package led_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        HOLD   = 2'd3
    } arb_state_t;

    localparam int HOLD_W = 19;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/led_hold_timer.sv
// Display-hold down-counter: loads a start value, decrements on request and
// flags when it has reached zero.
module led_hold_timer
    import led_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [HOLD_W-1:0] load_val,
    input  logic              dec,
    output logic              zero
);

    logic [HOLD_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/led_write_arbiter.sv
// Two-master round-robin arbiter for the LED display register with a
// post-write display hold. Optional M0 lock feature: LED_ARB_LOCK_EN.
module led_write_arbiter
    import led_arb_pkg::*;
#(
    parameter int DW          = 32,
    parameter int HOLD_CYCLES = 30000
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic          M0_REQ_I,
    input  logic          M0_WE_I,
    input  logic [DW-1:0] M0_DAT_I,
    output logic          M0_ACK_O,
    output logic [DW-1:0] M0_DAT_O,
    input  logic          M1_REQ_I,
    input  logic          M1_WE_I,
    input  logic [DW-1:0] M1_DAT_I,
    output logic          M1_ACK_O,
    output logic [DW-1:0] M1_DAT_O,
`ifdef LED_ARB_LOCK_EN
    input  logic          M0_LOCK_I,
`endif
    output logic          LED_WE_O,
    output logic [DW-1:0] LED_DAT_O,
    input  logic [DW-1:0] LED_DAT_I,
    output logic          BUSY_O,
    output arb_state_t    DBG_STATE_O
);

    // Master interface: REQ is held until a one-cycle ACK; a REQ that drops
    // before its ACK cancels the transfer with no side effects.
    localparam int                HOLD_LOAD_I = (HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0;
    localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_W'(HOLD_LOAD_I);
    localparam logic              HOLD_EN     = (HOLD_CYCLES != 0);

    logic lock;
`ifdef LED_ARB_LOCK_EN
    assign lock = M0_LOCK_I;
`else
    assign lock = 1'b0;
`endif

    arb_state_t    state_q, state_d;
    logic          last_q, last_d;
    logic          ack0_q, ack0_d, ack1_q, ack1_d;
    logic          we_q, we_d, busy_q;
    logic [DW-1:0] led_dat_q, led_dat_d, rd0_q, rd0_d, rd1_q, rd1_d;
    logic          timer_load, timer_dec, timer_zero;

    logic          sel, req_sel, we_sel;
    logic [DW-1:0] dat_sel;

    assign sel     = (state_q == GRANT1) ? M1 : M0;
    assign req_sel = (sel == M1) ? M1_REQ_I : M0_REQ_I;
    assign we_sel  = (sel == M1) ? M1_WE_I : M0_WE_I;
    assign dat_sel = (sel == M1) ? M1_DAT_I : M0_DAT_I;

    led_hold_timer u_hold_timer (
        .clk      (CLK_I),
        .rst_n    (RST_I),
        .load     (timer_load),
        .load_val (HOLD_LOAD),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        we_d       = 1'b0;
        led_dat_d  = led_dat_q;
        rd0_d      = rd0_q;
        rd1_d      = rd1_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                // Locked: M1 is invisible to arbitration.
                if (M0_REQ_I && M1_REQ_I && !lock) begin
                    state_d = (last_q == M0) ? GRANT1 : GRANT0;
                end else if (M0_REQ_I) begin
                    state_d = GRANT0;
                end else if (M1_REQ_I && !lock) begin
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                state_d = IDLE;
                if (req_sel) begin
                    if (sel == M0) ack0_d = 1'b1;
                    else           ack1_d = 1'b1;
                    last_d = sel;
                    if (we_sel) begin
                        we_d      = 1'b1;
                        led_dat_d = dat_sel;
                        if (HOLD_EN && !((sel == M0) && lock)) begin
                            state_d    = HOLD;
                            timer_load = 1'b1;
                        end
                    end else if (sel == M0) begin
                        rd0_d = LED_DAT_I;
                    end else begin
                        rd1_d = LED_DAT_I;
                    end
                end
            end
            HOLD: begin
                if (timer_zero) state_d = IDLE;
                else            timer_dec = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q   <= IDLE;
            last_q    <= M1;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            led_dat_q <= '0;
            rd0_q     <= '0;
            rd1_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            we_q      <= we_d;
            busy_q    <= (state_d != IDLE);
            led_dat_q <= led_dat_d;
            rd0_q     <= rd0_d;
            rd1_q     <= rd1_d;
        end
    end

    assign M0_ACK_O    = ack0_q;
    assign M1_ACK_O    = ack1_q;
    assign M0_DAT_O    = rd0_q;
    assign M1_DAT_O    = rd1_q;
    assign LED_WE_O    = we_q;
    assign LED_DAT_O   = led_dat_q;
    assign BUSY_O      = busy_q;
    assign DBG_STATE_O = state_q;

endmodule

// File: tb/tb_led_write_arbiter.sv
// Bench for led_write_arbiter: two instances (hold 4 and hold 0) share the
// stimulus and are checked each cycle against a transaction-level model.
module tb_led_write_arbiter;

    localparam int DW     = 32;
    localparam int HOLD_A = 4;
    localparam int HOLD_Z = 0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_we, m1_req, m1_we, m0_lock;
    logic [DW-1:0] m0_dat, m1_dat, led_in;

    logic          a_m0_ack, a_m1_ack, a_led_we, a_busy;
    logic [DW-1:0] a_m0_dat, a_m1_dat, a_led_dat;
    logic          z_m0_ack, z_m1_ack, z_led_we, z_busy;
    logic [DW-1:0] z_m0_dat, z_m1_dat, z_led_dat;
    led_arb_pkg::arb_state_t a_state, z_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_write_arbiter #(.DW(DW), .HOLD_CYCLES(HOLD_A)) dut_a (
        .CLK_I(clk), .RST_I(rst_n),
        .M0_REQ_I(m0_req), .M0_WE_I(m0_we), .M0_DAT_I(m0_dat), .M0_ACK_O(a_m0_ack), .M0_DAT_O(a_m0_dat),
        .M1_REQ_I(m1_req), .M1_WE_I(m1_we), .M1_DAT_I(m1_dat), .M1_ACK_O(a_m1_ack), .M1_DAT_O(a_m1_dat),
`ifdef LED_ARB_LOCK_EN
        .M0_LOCK_I(m0_lock),
`endif
        .LED_WE_O(a_led_we), .LED_DAT_O(a_led_dat), .LED_DAT_I(led_in), .BUSY_O(a_busy),
        .DBG_STATE_O(a_state)
    );

    led_write_arbiter #(.DW(DW), .HOLD_CYCLES(HOLD_Z)) dut_z (
        .CLK_I(clk), .RST_I(rst_n),
        .M0_REQ_I(m0_req), .M0_WE_I(m0_we), .M0_DAT_I(m0_dat), .M0_ACK_O(z_m0_ack), .M0_DAT_O(z_m0_dat),
        .M1_REQ_I(m1_req), .M1_WE_I(m1_we), .M1_DAT_I(m1_dat), .M1_ACK_O(z_m1_ack), .M1_DAT_O(z_m1_dat),
`ifdef LED_ARB_LOCK_EN
        .M0_LOCK_I(m0_lock),
`endif
        .LED_WE_O(z_led_we), .LED_DAT_O(z_led_dat), .LED_DAT_I(led_in), .BUSY_O(z_busy),
        .DBG_STATE_O(z_state)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: pending grant owner (-1 none), remaining hold cycles after an ack,
    // last acked master, and the expected registered outputs.
    int            mw[2];
    int            mr[2];
    int            ml[2];
    logic          mack0[2], mack1[2], mwe[2], mbusy[2];
    logic [DW-1:0] mld[2], mrd0[2], mrd1[2];

    function automatic int hold_of(input int d);
        return (d == 0) ? HOLD_A : HOLD_Z;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mw[d] = -1; mr[d] = 0; ml[d] = 1;
            mack0[d] = 1'b0; mack1[d] = 1'b0; mwe[d] = 1'b0; mbusy[d] = 1'b0;
            mld[d] = '0; mrd0[d] = '0; mrd1[d] = '0;
        end
    endtask

    task automatic model_step(input int d);
        logic          rq, wv, r1;
        logic [DW-1:0] dv;
        mack0[d] = 1'b0; mack1[d] = 1'b0; mwe[d] = 1'b0;
        if (mw[d] >= 0) begin
            rq = (mw[d] == 0) ? m0_req : m1_req;
            wv = (mw[d] == 0) ? m0_we : m1_we;
            dv = (mw[d] == 0) ? m0_dat : m1_dat;
            mr[d] = 0;
            if (rq) begin
                if (mw[d] == 0) mack0[d] = 1'b1; else mack1[d] = 1'b1;
                ml[d] = mw[d];
                if (wv) begin
                    mwe[d] = 1'b1;
                    mld[d] = dv;
                    mr[d]  = (mw[d] == 0 && m0_lock) ? 0 : hold_of(d);
                end else if (mw[d] == 0) begin
                    mrd0[d] = led_in;
                end else begin
                    mrd1[d] = led_in;
                end
            end
            mw[d] = -1;
        end else if (mr[d] > 0) begin
            mr[d] = mr[d] - 1;
        end else begin
            r1 = m1_req && !m0_lock;
            if (m0_req && r1) mw[d] = 1 - ml[d];
            else if (m0_req)  mw[d] = 0;
            else if (r1)      mw[d] = 1;
        end
        mbusy[d] = (mw[d] >= 0) || (mr[d] > 0);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else for (int d = 0; d < 2; d++) model_step(d);
        end
    end

    task automatic cmp(input int d, input logic ack0, input logic [DW-1:0] rd0, input logic ack1,
                       input logic [DW-1:0] rd1, input logic we, input logic [DW-1:0] ld, input logic busy);
        string p;
        p = (d == 0) ? "a" : "z";
        chk($sformatf("%s_m0_ack", p), ack0, mack0[d]);
        chk($sformatf("%s_m1_ack", p), ack1, mack1[d]);
        chk($sformatf("%s_m0_dat", p), rd0, mrd0[d]);
        chk($sformatf("%s_m1_dat", p), rd1, mrd1[d]);
        chk($sformatf("%s_led_we", p), we, mwe[d]);
        chk($sformatf("%s_busy", p), busy, mbusy[d]);
        if (mwe[d]) chk($sformatf("%s_led_dat", p), ld, mld[d]);
    endtask

    always @(negedge clk) begin
        cmp(0, a_m0_ack, a_m0_dat, a_m1_ack, a_m1_dat, a_led_we, a_led_dat, a_busy);
        cmp(1, z_m0_ack, z_m0_dat, z_m1_ack, z_m1_dat, z_led_we, z_led_dat, z_busy);
    end

    // One transfer on dut_a; the request is dropped as soon as its ack is seen.
    task automatic xfer(input int m, input logic w, input logic [DW-1:0] d, input int ncyc,
                        output int busy_n, output int ack_n, output int we_n, output logic [DW-1:0] led_at,
                        output logic [DW-1:0] rd_at);
        logic ack;
        busy_n = 0; ack_n = 0; we_n = 0; led_at = '0; rd_at = '0;
        if (m == 0) begin m0_req = 1'b1; m0_we = w; m0_dat = d; end
        else        begin m1_req = 1'b1; m1_we = w; m1_dat = d; end
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            busy_n += int'(a_busy);
            we_n   += int'(a_led_we);
            ack = (m == 0) ? a_m0_ack : a_m1_ack;
            if (ack) begin
                ack_n++;
                led_at = a_led_dat;
                rd_at  = (m == 0) ? a_m0_dat : a_m1_dat;
                if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    initial begin
        int            bn, an, wn, cnt, first;
        logic [DW-1:0] la, ra;
        int            order[$];
        int            idx[$];

        rst_n = 1'b0; m0_req = 1'b0; m0_we = 1'b0; m1_req = 1'b0; m1_we = 1'b0; m0_lock = 1'b0;
        m0_dat = '0; m1_dat = '0; led_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", a_busy, 1'b0);
        chk("reset_led_we", a_led_we, 1'b0);
        chk("reset_state", a_state, led_arb_pkg::IDLE);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Single write with a 4-cycle hold.
        xfer(0, 1'b1, 32'h1234_5678, 12, bn, an, wn, la, ra);
        chk("write_ack_count", an, 1);
        chk("write_we_count", wn, 1);
        chk("write_led_dat", la, 32'h1234_5678);
        chk("write_busy_cycles", bn, 5);

        // M1 read: readback returned with ack, no strobe, no hold.
        led_in = 32'hDEAD_BEEF;
        xfer(1, 1'b0, '0, 8, bn, an, wn, la, ra);
        chk("read_ack_count", an, 1);
        chk("read_dat", ra, 32'hDEAD_BEEF);
        chk("read_we_count", wn, 0);
        chk("read_busy_cycles", bn, 1);

        // Reset in the middle of a hold, M1 waiting across the release.
        m0_req = 1'b1; m0_we = 1'b1; m0_dat = 32'hA5A5_0001;
        cnt = 0;
        for (int i = 0; i < 6 && cnt == 0; i++) begin
            @(negedge clk);
            if (a_m0_ack) begin cnt = 1; m0_req = 1'b0; end
        end
        chk("pre_reset_ack", cnt, 1);
        @(negedge clk);
        chk("pre_reset_busy", a_busy, 1'b1);
        #2 rst_n = 1'b0;
        m1_req = 1'b1; m1_we = 1'b1; m1_dat = 32'h0BAD_F00D;
        #1;
        chk("async_busy", a_busy, 1'b0);
        chk("async_led_we", a_led_we, 1'b0);
        chk("async_led_dat", a_led_dat, '0);
        chk("async_m1_dat", a_m1_dat, '0);
        chk("async_m0_ack", a_m0_ack, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        first = -1;
        for (int i = 0; i < 10 && first < 0; i++) begin
            @(negedge clk);
            if (a_m0_ack) first = 0;
            if (a_m1_ack) begin first = 1; m1_req = 1'b0; end
        end
        m1_req = 1'b0;
        chk("post_reset_grant", first, 1);
        repeat (8) @(negedge clk);

        // Tie from reset: M0 twice, M1 once -> M0, M1, M0.
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b1; m0_dat = 32'h0000_00A1;
        m1_req = 1'b1; m1_we = 1'b1; m1_dat = 32'h0000_00B1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_m0_ack && m0_req) begin
                order.push_back(0);
                cnt++;
                if (cnt == 1) m0_dat = 32'h0000_00A2;
                else          m0_req = 1'b0;
            end
            if (a_m1_ack && m1_req) begin
                order.push_back(1);
                m1_req = 1'b0;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        chk("tie_ack_total", order.size(), 3);
        if (order.size() == 3) begin
            chk("tie_first", order[0], 0);
            chk("tie_second", order[1], 1);
            chk("tie_third", order[2], 0);
        end
        repeat (10) @(negedge clk);

        // Back-to-back writes on the zero-hold instance.
        m0_req = 1'b1; m0_we = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            m0_dat = 32'hC000_0000 + 32'(i);
            if (z_m0_ack) idx.push_back(i);
        end
        m0_req = 1'b0;
        chk("b2b_ack_count", idx.size(), 7);
        if (idx.size() > 0) chk("b2b_first_ack", idx[0], 1);
        for (int k = 1; k < idx.size(); k++) chk("b2b_ack_spacing", idx[k] - idx[k-1], 2);
        repeat (10) @(negedge clk);

        // Request withdrawn before its ack: no transfer on either instance.
        m1_req = 1'b1; m1_we = 1'b1; m1_dat = 32'h5555_AAAA;
        an = 0; bn = 0; wn = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) m1_req = 1'b0;
            an += int'(a_m1_ack) + int'(z_m1_ack);
            bn += int'(a_busy);
            wn += int'(a_led_we) + int'(z_led_we);
        end
        chk("drop_ack_count", an, 0);
        chk("drop_we_count", wn, 0);
        chk("drop_busy_cycles", bn, 1);

`ifdef LED_ARB_LOCK_EN
        // Lock: M1 starved while locked, served right after release.
        m0_lock = 1'b1;
        m1_req = 1'b1; m1_we = 1'b1; m1_dat = 32'h1111_2222;
        an = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            an += int'(a_m1_ack);
        end
        chk("lock_m1_acks", an, 0);
        m0_lock = 1'b0;
        an = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (a_m1_ack) begin an++; m1_req = 1'b0; end
        end
        m1_req = 1'b0;
        chk("unlock_m1_ack", an, 1);
        repeat (8) @(negedge clk);
`endif

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_write_arbiter.md
LED_WRITE_ARBITER -- requirements
Module: led_write_arbiter

Interface
REQ-001 Parameter: DW, 32, width of all data ports.
REQ-002 Parameter: HOLD_CYCLES, 30000, minimum display-hold cycles after each granted transfer; 0..524287, 19-bit counter.
REQ-003 Clocking and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-004 Port: CLK_I  in  1  system clock, all logic on rising edge.
REQ-005 Port: RST_I  in  1  asynchronous active-low reset.
REQ-006 Port: M0_REQ_I  in  1  master 0 (CPU bridge) request, held until ack.
REQ-007 Port: M0_WE_I  in  1  master 0 write (1) / read (0).
REQ-008 Port: M0_DAT_I  in  DW  master 0 write data.
REQ-009 Port: M0_ACK_O  out  1  master 0 one-cycle completion pulse.
REQ-010 Port: M0_DAT_O  out  DW  master 0 read data, valid with M0_ACK_O.
REQ-011 Port: M1_REQ_I / M1_WE_I / M1_DAT_I / M1_ACK_O / M1_DAT_O: same as M0, master 1 (debug/status source).
REQ-012 Port: LED_WE_O  out  1  write strobe to display data register.
REQ-013 Port: LED_DAT_O  out  DW  write data to display register.
REQ-014 Port: LED_DAT_I  in  DW  readback of display register.
REQ-015 Port: BUSY_O  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, GRANT0, GRANT1, HOLD; all outputs registered.
REQ-017 IDLE: only M0 requesting -> GRANT0; only M1 -> GRANT1; both -> master not granted last (round-robin); none -> stay IDLE.
REQ-018 Request-to-ack latency: request seen in IDLE at edge N -> ACK high during cycle N+1 through N+2 (exactly one cycle).
REQ-019 GRANTx with WE=1: LED_WE_O=1 and LED_DAT_O=Mx_DAT_I sampled at grant for exactly one cycle, concurrent with Mx_ACK_O.
REQ-020 GRANTx with WE=0: LED_WE_O stays 0; Mx_DAT_O=LED_DAT_I, Mx_ACK_O=1 for one cycle.
REQ-021 After GRANTx: HOLD_CYCLES=0 -> IDLE; else HOLD, counter loaded HOLD_CYCLES-1, decrement per cycle; at 0 -> IDLE.
REQ-022 Reads skip HOLD and go straight to IDLE.
REQ-023 Requests during GRANT/HOLD wait; they are not lost and are arbitrated in the next IDLE cycle.
REQ-024 Request dropped before ack: no transfer, no ack; arbitration restarts from IDLE.
REQ-025 Last-granted pointer updates only on an acked transfer.
REQ-026 Mx_DAT_O holds its last read value between acks.

Reset
REQ-027 RST_I low, asynchronous: state=IDLE, all ACK/WE/BUSY=0, all DAT_O=0, hold counter=0, last-granted=M1 (M0 wins the first tie).
REQ-028 Reset during GRANT or HOLD aborts without ack; after release, still-asserted requests are re-arbitrated from IDLE.

Configuration
REQ-029 Macro LED_ARB_LOCK_EN defined: extra port M0_LOCK_I (in, 1); while high, M1 is never granted and M0 requests bypass HOLD (GRANT0 -> IDLE).
REQ-030 LED_ARB_LOCK_EN undefined: port absent; behaviour exactly as REQ-016..028.

Structure
REQ-031 Shared package/include led_arb_pkg: state encodings, HOLD counter width (19), master index constants M0=0/M1=1.
REQ-032 One sub-module led_hold_timer (load, decrement, zero flag); FSM and data muxing stay in the top module.

Verification
REQ-033 Reset: drive RST_I=0 mid-HOLD -> all outputs 0 immediately; release with M1_REQ_I high -> M1 granted from IDLE.
REQ-034 Single write: M0 writes 0x12345678, HOLD_CYCLES=4 -> LED_WE_O one cycle with 0x12345678, M0_ACK_O same cycle, BUSY_O high 5 cycles total.
REQ-035 Tie: M0 and M1 both request from reset -> M0 first, M1 acked after hold; repeat tie -> M1 first.
REQ-036 Read: LED_DAT_I=0xDEADBEEF, M1 read -> M1_DAT_O=0xDEADBEEF with ack, LED_WE_O never high, no HOLD.
REQ-037 HOLD_CYCLES=0, back-to-back M0 writes -> one ack every 2 cycles.
REQ-038 With LED_ARB_LOCK_EN, M0_LOCK_I=1, M1 requesting 20 cycles -> no M1_ACK_O; lock drop -> M1 acked within 2 cycles.
